// File: rtl/spi_pkg.sv
// Shared types and code-decoding helpers for the SPI MISO router.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_FAULT
    } state_t;

    localparam int CODE_W = 16;

    function automatic logic [4:0] popcount_zero(input logic [CODE_W-1:0] code);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < CODE_W; i++) begin
            n = n + 5'(~code[i]);
        end
        return n;
    endfunction

    // Returns {valid, idx}; valid only when exactly one bit is low.
    function automatic logic [4:0] onecold_idx(input logic [CODE_W-1:0] code);
        logic [4:0] r;
        r = '0;
        if (popcount_zero(code) == 5'd1) begin
            for (int i = 0; i < CODE_W; i++) begin
                if (!code[i]) r = {1'b1, 4'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-stage synchroniser for asynchronous inputs, with a reset preload value.
module spi_sync #(
    parameter int             W       = 1,
    parameter int             STAGES  = 2,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [STAGES-1:0][W-1:0] stg_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) stg_q[i] <= RST_VAL;
        end else begin
            stg_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) stg_q[i] <= stg_q[i-1];
        end
    end

    assign q_o = stg_q[STAGES-1];

endmodule

// File: rtl/spi_miso_router.sv
// Latches the one-cold chip select per frame, routes the selected MISO line,
// counts SCLK edges and flags illegal or changing select codes.
module spi_miso_router #(
    parameter int N_CH        = 5,
    parameter int FRAME_BITS  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_CH-1:0]                  cs_code,
    input  logic                             sclk,
    input  logic [N_CH-1:0]                  miso_in,
    output logic                             miso_out,
    output logic [$clog2(N_CH)-1:0]          sel_idx,
    output logic                             busy,
    output logic [$clog2(FRAME_BITS+1)-1:0]  bit_cnt,
    output logic                             frame_done,
    output logic                             err_multi,
    output logic                             err_change,
    output logic                             err_short,
    input  logic                             err_clr
);
    import spi_pkg::*;

    localparam int IDXW = $clog2(N_CH);
    localparam int CW   = $clog2(FRAME_BITS+1);
    localparam logic [CW-1:0] FULL = CW'(FRAME_BITS);

    logic [N_CH-1:0] cs_s, miso_s;
    logic            sclk_s;

    spi_sync #(.W(N_CH), .STAGES(SYNC_STAGES), .RST_VAL({N_CH{1'b1}})) u_cs (
        .clk(clk), .rst(rst), .d_i(cs_code), .q_o(cs_s)
    );
    spi_sync #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .d_i(sclk), .q_o(sclk_s)
    );
    spi_sync #(.W(N_CH), .STAGES(SYNC_STAGES), .RST_VAL({N_CH{1'b1}})) u_miso (
        .clk(clk), .rst(rst), .d_i(miso_in), .q_o(miso_s)
    );

    state_t          state_q, state_d;
    logic [IDXW-1:0] sel_q, sel_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [N_CH-1:0] code_q, code_d;
    logic            miso_q, miso_d, busy_q, busy_d;
    logic            done_q, done_d, short_q, short_d;
    logic            emulti_q, emulti_d, echange_q, echange_d;
    logic            sclk_prev_q, rise;
    logic            set_multi, set_change, cs_idle;
    logic [CODE_W-1:0] code16;
    logic [4:0]      oc;

    always_comb begin
        code16 = '1;
        code16[N_CH-1:0] = cs_s;
    end

    assign oc      = onecold_idx(code16);
    assign cs_idle = &cs_s;
    assign rise    = sclk_s & ~sclk_prev_q;
    assign cnt_inc = (rise && cnt_q != FULL) ? cnt_q + CW'(1) : cnt_q;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        code_d     = code_q;
        miso_d     = miso_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        short_d    = 1'b0;
        set_multi  = 1'b0;
        set_change = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                miso_d = 1'b1;
                if (cs_idle) begin
                    state_d = ST_IDLE;
                end else if (oc[4]) begin
                    state_d = ST_ACTIVE;
                    sel_d   = oc[IDXW-1:0];
                    code_d  = cs_s;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    state_d   = ST_FAULT;
                    busy_d    = 1'b1;
                    set_multi = 1'b1;
                end
            end
            ST_ACTIVE: begin
                cnt_d  = cnt_inc;
                miso_d = miso_s[sel_q];
                // Same-cycle edge and release: judge the frame on the new count.
                if (cs_idle) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    miso_d  = 1'b1;
                    done_d  = (cnt_inc == FULL);
                    short_d = (cnt_inc != FULL);
                end else if (cs_s != code_q) begin
                    state_d    = ST_FAULT;
                    miso_d     = 1'b1;
                    set_change = 1'b1;
                    set_multi  = (popcount_zero(code16) > 5'd1);
                end
            end
            ST_FAULT: begin
                miso_d = 1'b1;
                busy_d = 1'b1;
                if (cs_idle) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                miso_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
        emulti_d  = set_multi  | (emulti_q  & ~err_clr);
        echange_d = set_change | (echange_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            code_q      <= '1;
            miso_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            short_q     <= 1'b0;
            emulti_q    <= 1'b0;
            echange_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            code_q      <= code_d;
            miso_q      <= miso_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            short_q     <= short_d;
            emulti_q    <= emulti_d;
            echange_q   <= echange_d;
            sclk_prev_q <= sclk_s;
        end
    end

    assign miso_out   = miso_q;
    assign sel_idx    = sel_q;
    assign busy       = busy_q;
    assign bit_cnt    = cnt_q;
    assign frame_done = done_q;
    assign err_short  = short_q;
    assign err_multi  = emulti_q;
    assign err_change = echange_q;

endmodule

// File: tb/tb_spi_miso_router.sv
// Directed bench for spi_miso_router: expected values queued at stimulus,
// popped and compared when the DUT output is sampled.
module tb_spi_miso_router;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] cs_code = '1;
    logic         sclk = 1'b0;
    logic [N-1:0] miso_in = '1;
    logic         err_clr = 1'b0;
    logic         miso_out, busy, frame_done, err_multi, err_change, err_short;
    logic [2:0]   sel_idx;
    logic [4:0]   bit_cnt;

    int sb[$];
    int vec = 0;
    int miss = 0;
    int nd = 0;
    int ns = 0;

    spi_miso_router dut (
        .clk(clk), .rst(rst), .cs_code(cs_code), .sclk(sclk),
        .miso_in(miso_in), .miso_out(miso_out), .sel_idx(sel_idx),
        .busy(busy), .bit_cnt(bit_cnt), .frame_done(frame_done),
        .err_multi(err_multi), .err_change(err_change),
        .err_short(err_short), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (frame_done) nd++;
            if (err_short) ns++;
        end
    endtask

    task automatic chk(input string tag, input int obs);
        int exp;
        vec++;
        if (sb.size() == 0) begin
            miss++;
            $error("FAIL %s: scoreboard empty, observed %0d", tag, obs);
        end else begin
            exp = sb.pop_front();
            assert (obs === exp) else begin
                miss++;
                $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            end
        end
    endtask

    task automatic start(input logic [N-1:0] cs);
        miso_in = '1;
        cs_code = cs;
        nd = 0;
        ns = 0;
        run(4);
    endtask

    task automatic bits(input int ch, input int n, input logic [15:0] pat,
                        input bit rel_last);
        logic prev;
        prev = 1'b1;
        for (int i = 0; i < n; i++) begin
            miso_in[ch] = pat[15-i];
            sclk = 1'b0;
            sb.push_back(int'(prev));
            run(2);
            chk("miso_hold", int'(miso_out));
            sb.push_back(int'(pat[15-i]));
            run(1);
            chk("miso_new", int'(miso_out));
            prev = pat[15-i];
            if (rel_last && i == n-1) cs_code = '1;
            sclk = 1'b1;
            run(3);
        end
        sclk = 1'b0;
        run(3);
    endtask

    task automatic release_cs();
        cs_code = '1;
        run(5);
    endtask

    initial begin
        // Reset
        run(3);
        sb.push_back(1); chk("rst_miso", int'(miso_out));
        sb.push_back(0); chk("rst_busy", int'(busy));
        sb.push_back(0); chk("rst_cnt", int'(bit_cnt));
        sb.push_back(0); chk("rst_sel", int'(sel_idx));
        rst = 1'b0;
        run(2);

        // 1: full frame on channel 1
        start(5'b11101);
        sb.push_back(1); chk("t1_sel", int'(sel_idx));
        sb.push_back(1); chk("t1_busy", int'(busy));
        bits(1, 16, 16'hA5C3, 1'b0);
        sb.push_back(16); chk("t1_cnt", int'(bit_cnt));
        release_cs();
        sb.push_back(1); chk("t1_done", nd);
        sb.push_back(0); chk("t1_short", ns);
        sb.push_back(0); chk("t1_busy_end", int'(busy));
        sb.push_back(1); chk("t1_miso_idle", int'(miso_out));

        // 2: short frame on channel 2
        start(5'b11011);
        bits(2, 9, 16'h6D00, 1'b0);
        release_cs();
        sb.push_back(2); chk("t2_sel", int'(sel_idx));
        sb.push_back(9); chk("t2_cnt", int'(bit_cnt));
        sb.push_back(1); chk("t2_short", ns);
        sb.push_back(0); chk("t2_done", nd);
        sb.push_back(0); chk("t2_busy", int'(busy));

        // 3: multi-zero code from idle
        start(5'b11001);
        sb.push_back(1); chk("t3_multi", int'(err_multi));
        sb.push_back(1); chk("t3_busy", int'(busy));
        sb.push_back(1); chk("t3_miso", int'(miso_out));
        release_cs();
        sb.push_back(0); chk("t3_busy_end", int'(busy));
        sb.push_back(1); chk("t3_multi_sticky", int'(err_multi));
        sb.push_back(0); chk("t3_noshort", ns);
        err_clr = 1'b1;
        run(1);
        err_clr = 1'b0;
        sb.push_back(0); chk("t3_clr", int'(err_multi));

        // 4: code change mid-frame
        start(5'b11110);
        bits(0, 4, 16'h5000, 1'b0);
        sb.push_back(4); chk("t4_cnt", int'(bit_cnt));
        miso_in = '0;
        cs_code = 5'b10111;
        run(4);
        sb.push_back(1); chk("t4_change", int'(err_change));
        sb.push_back(0); chk("t4_multi", int'(err_multi));
        sb.push_back(1); chk("t4_miso", int'(miso_out));
        sb.push_back(1); chk("t4_busy", int'(busy));
        release_cs();
        sb.push_back(0); chk("t4_busy_end", int'(busy));
        sb.push_back(0); chk("t4_done", nd);
        sb.push_back(0); chk("t4_short", ns);
        err_clr = 1'b1;
        run(1);
        err_clr = 1'b0;
        sb.push_back(0); chk("t4_clr", int'(err_change));

        // 5: reset mid-frame, then a legal frame on channel 0
        start(5'b10111);
        bits(3, 7, 16'hFE00, 1'b0);
        sb.push_back(3); chk("t5_sel", int'(sel_idx));
        rst = 1'b1;
        cs_code = '1;
        run(1);
        sb.push_back(0); chk("t5_rst_busy", int'(busy));
        sb.push_back(0); chk("t5_rst_cnt", int'(bit_cnt));
        sb.push_back(0); chk("t5_rst_sel", int'(sel_idx));
        sb.push_back(1); chk("t5_rst_miso", int'(miso_out));
        sb.push_back(0); chk("t5_rst_pulses", nd + ns);
        rst = 1'b0;
        run(2);
        start(5'b11110);
        bits(0, 16, 16'h3C96, 1'b0);
        release_cs();
        sb.push_back(1); chk("t5_done", nd);
        sb.push_back(16); chk("t5_cnt", int'(bit_cnt));

        // 6: last edge and release together
        start(5'b01111);
        sb.push_back(4); chk("t6_sel", int'(sel_idx));
        bits(4, 16, 16'h81E7, 1'b1);
        run(2);
        sb.push_back(16); chk("t6_cnt", int'(bit_cnt));
        sb.push_back(1); chk("t6_done", nd);
        sb.push_back(0); chk("t6_short", ns);
        sb.push_back(0); chk("t6_busy", int'(busy));

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/spi_miso_router.md
Name: spi_miso_router

Overview:
- Parametrised, clocked successor to the combinational MISO select decoder. Routes the MISO line of one of N_CH SPI slaves to the master.
- The slave is chosen by a one-cold active-low chip-select code. The selection is latched for the whole frame, SCLK edges are counted, and illegal or changing select codes are flagged.
- Sits between the SPI master core and the slave MISO pins on the modem board.

Parameters:
- N_CH, 5, number of slave channels (width of cs_code and miso_in), 2..16.
- FRAME_BITS, 16, SCLK rising edges per complete frame.
- SYNC_STAGES, 2, synchroniser depth for sclk, cs_code and miso_in (>=2).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- cs_code  input  N_CH  active-low chip selects. Exactly one 0 selects that channel; all 1 means idle.
- sclk  input  1  SPI clock from master, asynchronous to clk.
- miso_in  input  N_CH  per-slave MISO lines.
- miso_out  output  1  routed MISO to master.
- sel_idx  output  $clog2(N_CH)  latched channel index.
- busy  output  1  frame in progress.
- bit_cnt  output  $clog2(FRAME_BITS+1)  SCLK rising edges counted in current frame.
- frame_done  output  1  1-cycle pulse on a complete, legal frame end.
- err_multi  output  1  sticky: more than one cs low seen.
- err_change  output  1  sticky: cs code changed during a frame.
- err_short  output  1  1-cycle pulse: frame ended with bit_cnt != FRAME_BITS.
- err_clr  input  1  clears the sticky error flags.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - miso_out=1, sel_idx=0, busy=0, bit_cnt=0.
  - frame_done=0, err_multi=0, err_change=0, err_short=0.
  - Synchronisers preload 1 (cs, sclk idle-high assumption for cs; sclk preloads 0).
  - Reset mid-frame aborts with no done or error pulse.
- All inputs are sampled through SYNC_STAGES flops. All logic below uses the synchronised values (cs_s, sclk_s, miso_s).
- SCLK rising edge: sclk_s=1 and previous sclk_s=0, detected with one extra flop.
- States: IDLE, ACTIVE, FAULT.
- IDLE:
  - cs_s all-ones: stay. miso_out=1.
  - cs_s one-cold at bit k: go to ACTIVE. sel_idx<=k, busy<=1, bit_cnt<=0.
  - cs_s has two or more zeros: go to FAULT, err_multi<=1.
- ACTIVE:
  - miso_out <= miso_s[sel_idx], registered, so there is one clk of latency after the synchroniser.
  - On each SCLK rising edge, bit_cnt increments and saturates at FRAME_BITS.
  - cs_s all-ones ends the frame: go to IDLE, busy<=0, miso_out<=1.
    - If bit_cnt==FRAME_BITS, pulse frame_done. Otherwise pulse err_short.
  - If the SCLK edge and cs release happen in the same cycle, the edge is counted first, then the end-of-frame check uses the incremented count.
  - Any other cs_s value different from the latched one-cold code:
    - Go to FAULT.
    - err_change<=1, plus err_multi<=1 if that value has multiple zeros.
- FAULT:
  - miso_out=1, busy=1.
  - Stays until cs_s is all-ones, then goes to IDLE with no frame_done and no err_short.
- err_clr clears the sticky flags the next cycle. If a new error is set in the same cycle, setting wins.
- bit_cnt holds its final value in IDLE until the next frame start.
- sel_idx holds its last value in IDLE and FAULT.

Decomposition:
- Shared package spi_pkg:
  - state enum ST_IDLE / ST_ACTIVE / ST_FAULT.
  - Function onecold_idx(code) returning {valid, idx}; valid=0 for all-ones or multi-zero.
  - Function popcount_zero(code) returning the number of zero bits in code.
- One sub-module, spi_sync: N-bit multi-stage synchroniser with a parametrised reset value. Instantiated for cs_code, sclk and miso_in.

Test Plan:
1. Reset, then N_CH=5, FRAME_BITS=16. cs=5'b11101, 16 SCLK pulses, miso_in[1] toggling pattern 0xA5C3 -> sel_idx=1; miso_out reproduces the pattern delayed by SYNC_STAGES+1 clk; frame_done pulses once; bit_cnt=16.
2. cs=5'b11011, only 9 SCLK pulses, then release -> err_short pulses one cycle; no frame_done; bit_cnt=9; busy=0.
3. cs=5'b11001 from IDLE -> FAULT; err_multi=1; miso_out=1. Release to all-ones -> IDLE. err_clr -> err_multi=0.
4. cs=5'b11110, 4 SCLK pulses, then change to 5'b10111 -> err_change=1, miso_out=1, FAULT. Release -> IDLE, no frame_done.
5. rst asserted after 7 bits of a frame on channel 3 -> all outputs return to reset values next cycle. A following legal 16-bit frame on channel 0 completes with frame_done.
6. Final SCLK edge and cs release in the same synchronised cycle -> bit_cnt=16, frame_done pulses, no err_short.
